dma_mch_csr: RTL and testbench

DMA_MCH_CSR -- requirements
Module: dma_mch_csr

---
 rtl/dma_mch_csr.sv | 163 ++++++++++++++++
 tb/tb_dma_mch_csr.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_mch_csr.sv
// Multi-channel DMA control/status register block on a Wishbone classic slave.
// Latency: ack/err one cycle after the access is seen; engine pulses and irq_o are registered.
// Backpressure: none; every access gets exactly one response, and the next access is taken once it drops.
module dma_mch_csr #(
   parameter int NUM_CH = 4,
   parameter int LEN_W  = 16
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      wb_cyc_i,
   input  logic                      wb_stb_i,
   input  logic                      wb_we_i,
   input  logic [8:0]                wb_adr_i,
   input  logic [31:0]               wb_dat_i,
   input  logic [3:0]                wb_sel_i,
   output logic [31:0]               wb_dat_o,
   output logic                      wb_ack_o,
   output logic                      wb_err_o,
   output logic [NUM_CH*32-1:0]      ch_src_o,
   output logic [NUM_CH*32-1:0]      ch_dst_o,
   output logic [NUM_CH*LEN_W-1:0]   ch_len_o,
   output logic [NUM_CH-1:0]         ch_go_o,
   output logic [NUM_CH-1:0]         ch_abort_o,
   input  logic [NUM_CH-1:0]         ch_busy_i,
   input  logic [NUM_CH-1:0]         ch_done_i,
   input  logic [NUM_CH-1:0]         ch_err_i,
   output logic                      irq_o
);

   localparam logic [2:0] R_SRC  = 3'd0;
   localparam logic [2:0] R_DST  = 3'd1;
   localparam logic [2:0] R_LEN  = 3'd2;
   localparam logic [2:0] R_CTRL = 3'd3;
   localparam logic [2:0] R_STAT = 3'd4;
   localparam logic [3:0] NCH    = 4'(NUM_CH);

   logic [31:0]       src_q [NUM_CH];
   logic [31:0]       dst_q [NUM_CH];
   logic [LEN_W-1:0]  len_q [NUM_CH];
   logic [NUM_CH-1:0] ie_q, done_q, err_q, irq_mask_q;

   logic              acc, adr_ok, wr, ctrl_wr, stat_wr;
   logic [2:0]        ch_idx, reg_idx;
   logic [31:0]       bmask, rdata;
   logic [NUM_CH-1:0] wr_hit, len_nz, go_req, go_fire, err_go, abort_fire;
   logic [NUM_CH-1:0] done_clr, err_clr, irq_stat;
   logic              unused_adr;

   assign acc        = wb_cyc_i & wb_stb_i & ~wb_ack_o & ~wb_err_o;
   assign ch_idx     = wb_adr_i[7:5];
   assign reg_idx    = wb_adr_i[4:2];
   assign bmask      = {{8{wb_sel_i[3]}}, {8{wb_sel_i[2]}}, {8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};
   assign wr         = acc & adr_ok & wb_we_i;
   assign ctrl_wr    = (reg_idx == R_CTRL) & wb_sel_i[0];
   assign stat_wr    = (reg_idx == R_STAT);
   assign irq_stat   = ie_q & (done_q | err_q);
   assign unused_adr = &{1'b0, wb_adr_i[1:0]};

   always_comb begin
      adr_ok = 1'b0;
      if (wb_adr_i[8])
         adr_ok = (wb_adr_i[7:2] == 6'd0) || (wb_adr_i[7:2] == 6'd1);
      else
         adr_ok = (reg_idx <= R_STAT) && ({1'b0, ch_idx} < NCH);
   end

   always_comb begin
      wr_hit = '0;
      len_nz = '0;
      for (int n = 0; n < NUM_CH; n++) begin
         wr_hit[n] = wr & ~wb_adr_i[8] & (ch_idx == 3'(n));
         len_nz[n] = |len_q[n];
      end
   end

   // GO with a zero length is a programming error reported through ERR rather than a start.
   assign go_req     = wr_hit & {NUM_CH{ctrl_wr & wb_dat_i[0]}};
   assign go_fire    = go_req & ~ch_busy_i & len_nz;
   assign err_go     = go_req & ~ch_busy_i & ~len_nz;
   assign abort_fire = wr_hit & {NUM_CH{ctrl_wr & wb_dat_i[2]}} & ch_busy_i;
   assign done_clr   = wr_hit & {NUM_CH{stat_wr & wb_sel_i[2] & wb_dat_i[16]}};
   assign err_clr    = wr_hit & {NUM_CH{stat_wr & wb_sel_i[1] & wb_dat_i[8]}};

   always_comb begin
      rdata = '0;
      if (wb_adr_i[8]) begin
         if (wb_adr_i[2])
            rdata = 32'(irq_mask_q);
         else
            rdata = 32'(irq_stat);
      end else begin
         for (int n = 0; n < NUM_CH; n++) begin
            if (ch_idx == 3'(n)) begin
               case (reg_idx)
                  R_SRC:   rdata = src_q[n];
                  R_DST:   rdata = dst_q[n];
                  R_LEN:   rdata = 32'(len_q[n]);
                  R_CTRL:  rdata = {30'd0, ie_q[n], 1'b0};
                  R_STAT:  rdata = {15'd0, done_q[n], 7'd0, err_q[n], 7'd0, ch_busy_i[n]};
                  default: ;
               endcase
            end
         end
      end
   end

   always_comb begin
      ch_src_o = '0;
      ch_dst_o = '0;
      ch_len_o = '0;
      for (int n = 0; n < NUM_CH; n++) begin
         ch_src_o[32*n +: 32]       = src_q[n];
         ch_dst_o[32*n +: 32]       = dst_q[n];
         ch_len_o[LEN_W*n +: LEN_W] = len_q[n];
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int n = 0; n < NUM_CH; n++) begin
            src_q[n] <= '0;
            dst_q[n] <= '0;
            len_q[n] <= '0;
         end
         ie_q       <= '0;
         done_q     <= '0;
         err_q      <= '0;
         irq_mask_q <= '1;
         wb_ack_o   <= 1'b0;
         wb_err_o   <= 1'b0;
         wb_dat_o   <= '0;
         ch_go_o    <= '0;
         ch_abort_o <= '0;
         irq_o      <= 1'b0;
      end else begin
         wb_ack_o   <= acc & adr_ok;
         wb_err_o   <= acc & ~adr_ok;
         wb_dat_o   <= (acc & adr_ok & ~wb_we_i) ? rdata : '0;
         ch_go_o    <= go_fire;
         ch_abort_o <= abort_fire;
         // Engine set beats a same-cycle software clear so no event is lost.
         done_q     <= ch_done_i | (done_q & ~done_clr);
         err_q      <= ch_err_i | err_go | (err_q & ~err_clr);
         irq_o      <= |(irq_stat & irq_mask_q);
         if (wr & wb_adr_i[8] & wb_adr_i[2] & wb_sel_i[0])
            irq_mask_q <= wb_dat_i[NUM_CH-1:0];
         for (int n = 0; n < NUM_CH; n++) begin
            if (wr_hit[n] & ~ch_busy_i[n]) begin
               case (reg_idx)
                  R_SRC:   src_q[n] <= (src_q[n] & ~bmask) | (wb_dat_i & bmask);
                  R_DST:   dst_q[n] <= (dst_q[n] & ~bmask) | (wb_dat_i & bmask);
                  R_LEN:   len_q[n] <= (len_q[n] & ~bmask[LEN_W-1:0]) |
                                       (wb_dat_i[LEN_W-1:0] & bmask[LEN_W-1:0]);
                  default: ;
               endcase
            end
            if (wr_hit[n] & ctrl_wr)
               ie_q[n] <= wb_dat_i[1];
         end
      end
   end

endmodule

// File: tb/tb_dma_mch_csr.sv
// Bench for dma_mch_csr: directed register-map scenarios followed by randomized
// bus/engine traffic checked against a register-level model.
module tb_dma_mch_csr;

   localparam int NUM_CH = 4;
   localparam int LEN_W  = 16;

   logic                     clk_i = 1'b0;
   logic                     rst_i;
   logic                     wb_cyc_i, wb_stb_i, wb_we_i;
   logic [8:0]               wb_adr_i;
   logic [31:0]              wb_dat_i;
   logic [3:0]               wb_sel_i;
   logic [31:0]              wb_dat_o;
   logic                     wb_ack_o, wb_err_o;
   logic [NUM_CH*32-1:0]     ch_src_o, ch_dst_o;
   logic [NUM_CH*LEN_W-1:0]  ch_len_o;
   logic [NUM_CH-1:0]        ch_go_o, ch_abort_o;
   logic [NUM_CH-1:0]        ch_busy_i, ch_done_i, ch_err_i;
   logic                     irq_o;

   always #5 clk_i = ~clk_i;

   dma_mch_csr #(.NUM_CH(NUM_CH), .LEN_W(LEN_W)) dut (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .wb_cyc_i   (wb_cyc_i),
      .wb_stb_i   (wb_stb_i),
      .wb_we_i    (wb_we_i),
      .wb_adr_i   (wb_adr_i),
      .wb_dat_i   (wb_dat_i),
      .wb_sel_i   (wb_sel_i),
      .wb_dat_o   (wb_dat_o),
      .wb_ack_o   (wb_ack_o),
      .wb_err_o   (wb_err_o),
      .ch_src_o   (ch_src_o),
      .ch_dst_o   (ch_dst_o),
      .ch_len_o   (ch_len_o),
      .ch_go_o    (ch_go_o),
      .ch_abort_o (ch_abort_o),
      .ch_busy_i  (ch_busy_i),
      .ch_done_i  (ch_done_i),
      .ch_err_i   (ch_err_i),
      .irq_o      (irq_o)
   );

   int n_cmp  = 0;
   int n_fail = 0;

   // Register-level model of the programmer-visible state.
   logic [31:0] m_src [4];
   logic [31:0] m_dst [4];
   logic [15:0] m_len [4];
   logic [3:0]  m_ie, m_done, m_err, m_mask;
   logic [3:0]  busy;
   logic [31:0] last_rd;
   logic        last_err;
   logic [3:0]  last_go, last_ab;

   assign ch_busy_i = busy;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                         input logic [3:0] s);
      logic [31:0] r;
      r = old;
      for (int i = 0; i < 4; i++)
         if (s[i]) r[8*i +: 8] = nw[8*i +: 8];
      return r;
   endfunction

   function automatic logic addr_ok(input logic [8:0] a);
      if (a[8]) return (a[7:2] <= 6'd1);
      return (a[7:5] < 3'd4) && (a[4:2] <= 3'd4);
   endfunction

   function automatic logic m_irq();
      return |(m_ie & (m_done | m_err) & m_mask);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 4; i++) begin
         m_src[i] = '0;
         m_dst[i] = '0;
         m_len[i] = '0;
      end
      m_ie = '0; m_done = '0; m_err = '0; m_mask = 4'hF;
   endtask

   function automatic logic [31:0] model_rd(input logic [8:0] a);
      logic [1:0] ci;
      ci = a[6:5];
      if (!addr_ok(a)) return 32'd0;
      if (a[8]) return a[2] ? {28'd0, m_mask} : {28'd0, m_ie & (m_done | m_err)};
      case (a[4:2])
         3'd0:    return m_src[ci];
         3'd1:    return m_dst[ci];
         3'd2:    return {16'd0, m_len[ci]};
         3'd3:    return {30'd0, m_ie[ci], 1'b0};
         default: return (32'(m_done[ci]) << 16) | (32'(m_err[ci]) << 8) | 32'(busy[ci]);
      endcase
   endfunction

   task automatic model_wr(input logic [8:0] a, input logic [31:0] d, input logic [3:0] s,
                           input logic [3:0] dn, input logic [3:0] er,
                           output logic [3:0] eg, output logic [3:0] ea);
      logic [1:0]  ci;
      logic [3:0]  cd, ce, se;
      logic [31:0] t;
      ci = a[6:5];
      cd = '0; ce = '0; se = '0; eg = '0; ea = '0;
      if (addr_ok(a)) begin
         if (a[8]) begin
            if (a[2] && s[0]) m_mask = d[3:0];
         end else begin
            case (a[4:2])
               3'd0: if (!busy[ci]) m_src[ci] = merge(m_src[ci], d, s);
               3'd1: if (!busy[ci]) m_dst[ci] = merge(m_dst[ci], d, s);
               3'd2: if (!busy[ci]) begin
                        t = merge({16'd0, m_len[ci]}, d, s);
                        m_len[ci] = t[15:0];
                     end
               3'd3: if (s[0]) begin
                        m_ie[ci] = d[1];
                        if (d[0] && !busy[ci]) begin
                           if (m_len[ci] == 16'd0) se[ci] = 1'b1;
                           else eg[ci] = 1'b1;
                        end
                        if (d[2] && busy[ci]) ea[ci] = 1'b1;
                     end
               default: begin
                  if (s[1] && d[8])  ce[ci] = 1'b1;
                  if (s[2] && d[16]) cd[ci] = 1'b1;
               end
            endcase
         end
      end
      m_done = (m_done & ~cd) | dn;
      m_err  = (m_err & ~ce) | er | se;
   endtask

   task automatic idle();
      @(posedge clk_i); #1;
      chk("irq", irq_o, m_irq());
      chk("go_idle", ch_go_o, 0);
      chk("abort_idle", ch_abort_o, 0);
      chk("resp_idle", {wb_ack_o, wb_err_o}, 0);
   endtask

   task automatic bus_wr(input logic [8:0] a, input logic [31:0] d, input logic [3:0] s,
                         input logic [3:0] dn, input logic [3:0] er);
      logic [3:0] eg, ea;
      logic       ok, irq_prev;
      ok = addr_ok(a);
      irq_prev = m_irq();
      model_wr(a, d, s, dn, er, eg, ea);
      wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = 1; wb_adr_i = a; wb_dat_i = d; wb_sel_i = s;
      ch_done_i = dn; ch_err_i = er;
      @(posedge clk_i); #1;
      wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0; ch_done_i = '0; ch_err_i = '0;
      last_go = ch_go_o; last_ab = ch_abort_o; last_err = wb_err_o;
      chk("wr_ack", wb_ack_o, ok);
      chk("wr_err", wb_err_o, !ok);
      chk("wr_go", ch_go_o, eg);
      chk("wr_abort", ch_abort_o, ea);
      chk("wr_irq_prev", irq_o, irq_prev);
      if (!ok) chk("wr_err_dat", wb_dat_o, 0);
      idle();
   endtask

   task automatic bus_rd(input logic [8:0] a);
      logic [31:0] exp;
      logic        ok;
      ok  = addr_ok(a);
      exp = model_rd(a);
      wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = 0; wb_adr_i = a; wb_sel_i = 4'hF;
      wb_dat_i = $urandom;
      @(posedge clk_i); #1;
      wb_cyc_i = 0; wb_stb_i = 0;
      last_rd = wb_dat_o; last_err = wb_err_o;
      chk("rd_ack", wb_ack_o, ok);
      chk("rd_err", wb_err_o, !ok);
      chk("rd_dat", wb_dat_o, exp);
      idle();
   endtask

   task automatic pulse(input logic [3:0] dn, input logic [3:0] er);
      logic irq_prev;
      irq_prev = m_irq();
      ch_done_i = dn; ch_err_i = er;
      @(posedge clk_i); #1;
      ch_done_i = '0; ch_err_i = '0;
      m_done = m_done | dn;
      m_err  = m_err | er;
      chk("pulse_irq_prev", irq_o, irq_prev);
      idle();
   endtask

   task automatic chk_outs();
      logic [127:0] es, ed;
      logic [63:0]  el;
      for (int i = 0; i < 4; i++) begin
         es[32*i +: 32] = m_src[i];
         ed[32*i +: 32] = m_dst[i];
         el[16*i +: 16] = m_len[i];
      end
      chk("ch_src_o", ch_src_o, es);
      chk("ch_dst_o", ch_dst_o, ed);
      chk("ch_len_o", ch_len_o, el);
   endtask

   initial begin
      logic [8:0]  a;
      logic [31:0] d;
      logic [3:0]  s, dn, er;
      int          op;

      rst_i = 1; wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0; wb_adr_i = '0; wb_dat_i = '0;
      wb_sel_i = '0; busy = '0; ch_done_i = '0; ch_err_i = '0;
      last_rd = '0; last_err = 0; last_go = '0; last_ab = '0;
      model_reset();
      repeat (3) @(posedge clk_i);
      #1;
      chk("rst_resp", {wb_ack_o, wb_err_o}, 0);
      chk("rst_pulses", {ch_go_o, ch_abort_o}, 0);
      chk("rst_irq", irq_o, 0);
      chk("rst_dat", wb_dat_o, 0);
      chk_outs();
      rst_i = 0;
      idle();
      bus_rd(9'h104);
      chk("mask_reset", last_rd, 32'hF);

      // Channel 1 programmed and started.
      bus_wr(9'h020, 32'h1000_0000, 4'hF, 0, 0);
      bus_wr(9'h024, 32'h2000_0000, 4'hF, 0, 0);
      bus_wr(9'h028, 32'h0000_0040, 4'hF, 0, 0);
      bus_wr(9'h02C, 32'h0000_0003, 4'hF, 0, 0);
      chk("go_ch1", last_go, 4'b0010);
      bus_rd(9'h02C);
      chk("ctrl_rd", last_rd, 32'h2);
      chk("len_ch1", ch_len_o[31:16], 16'h40);
      chk_outs();

      // Busy channel: data writes dropped, GO ignored, ABORT pulses.
      busy = 4'b0010;
      idle();
      bus_wr(9'h020, 32'hDEAD_BEEF, 4'hF, 0, 0);
      bus_wr(9'h02C, 32'h0000_0003, 4'hF, 0, 0);
      chk("go_busy", last_go, 4'b0000);
      bus_rd(9'h020);
      chk("src_kept", last_rd, 32'h1000_0000);
      bus_wr(9'h02C, 32'h0000_0006, 4'hF, 0, 0);
      chk("abort_ch1", last_ab, 4'b0010);
      busy = 4'b0000;
      idle();

      // Completion interrupt and its clear.
      pulse(4'b0010, 4'b0000);
      chk("irq_done", irq_o, 1);
      bus_rd(9'h030);
      chk("status_done", last_rd, 32'h0001_0000);
      bus_wr(9'h030, 32'h0001_0000, 4'hF, 0, 0);
      chk("irq_cleared", irq_o, 0);

      // Set wins over same-cycle clear.
      pulse(4'b0100, 4'b0000);
      bus_wr(9'h050, 32'h0001_0000, 4'hF, 4'b0100, 4'b0000);
      bus_rd(9'h050);
      chk("done_sticky", last_rd[16], 1);

      // Out-of-range channel and zero-length GO.
      bus_rd(9'h0A0);
      chk("oob_err", last_err, 1);
      chk("oob_dat", last_rd, 0);
      bus_wr(9'h008, 32'h0, 4'hF, 0, 0);
      bus_wr(9'h00C, 32'h1, 4'hF, 0, 0);
      chk("go_len0", last_go, 4'b0000);
      bus_rd(9'h010);
      chk("err_len0", last_rd[8], 1);

      // Masked interrupt and byte-lane write.
      bus_wr(9'h104, 32'h0, 4'h1, 0, 0);
      bus_wr(9'h00C, 32'h2, 4'hF, 0, 0);
      bus_rd(9'h100);
      chk("irq_stat_nz", last_rd[0], 1);
      chk("irq_masked", irq_o, 0);
      bus_wr(9'h020, 32'hFFFF_FFFF, 4'b0001, 0, 0);
      bus_rd(9'h020);
      chk("sel_byte0", last_rd, 32'h1000_00FF);
      bus_wr(9'h104, 32'hF, 4'h1, 0, 0);
      chk_outs();

      // Randomized traffic.
      for (int it = 0; it < 400; it++) begin
         op = $urandom_range(0, 9);
         if ($urandom_range(0, 9) == 0)
            a = {1'b1, 4'd0, 2'($urandom_range(0, 3)), 2'($urandom)};
         else
            a = {1'b0, 3'($urandom_range(0, 4)), 3'($urandom_range(0, 5)), 2'($urandom)};
         d = ($urandom_range(0, 2) == 0) ? 32'd0 : $urandom;
         s = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom);
         dn = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'd0;
         er = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'd0;
         if (op <= 4) begin
            bus_wr(a, d, s, dn, er);
         end else if (op <= 7) begin
            bus_rd(a);
         end else if (op == 8) begin
            pulse(4'($urandom) & 4'($urandom), 4'($urandom) & 4'($urandom));
         end else begin
            busy = 4'($urandom);
            idle();
         end
         chk_outs();
      end

      // Reset during an access: no response, engine inputs ignored, state cleared.
      busy = 4'b0000;
      idle();
      wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = 1; wb_adr_i = 9'h02C; wb_dat_i = 32'h3;
      wb_sel_i = 4'hF; ch_done_i = 4'hF; ch_err_i = 4'hF; rst_i = 1;
      @(posedge clk_i); #1;
      chk("rst_mid_resp", {wb_ack_o, wb_err_o}, 0);
      chk("rst_mid_go", ch_go_o, 0);
      chk("rst_mid_irq", irq_o, 0);
      wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0; ch_done_i = '0; ch_err_i = '0; rst_i = 0;
      model_reset();
      idle();
      bus_rd(9'h030);
      bus_rd(9'h104);
      chk_outs();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
